instr_prefetch_buffer: RTL and testbench

- Fetch stage directly upstream of the instruction memory. Issues word-aligned requests over the req/gnt/rvalid instruction-memory protocol and keeps one transaction outstanding at most.
- Buffers returned words, each with its fetch address, in a small FIFO.
- Presents buffered words to the decode stage through a valid/ready handshake.
- Handles branch redirects by flushing the FIFO and discarding the response of any aborted in-flight transaction.

---
 rtl/instr_prefetch_buffer.sv | 156 +++++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: single-outstanding req/gnt/rvalid fetcher feeding
// a small FIFO of {word, address} entries drained by decode over valid/ready.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// IDLE        | no transaction outstanding; start when enabled and not full
// WAIT_GNT    | request on the bus, held stable until the memory grants it
// WAIT_RVALID | granted, waiting for data that will be pushed into the FIFO
// WAIT_ABORT  | granted after a redirect, waiting for data that is dropped
module instr_prefetch_buffer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  busy_o,
  output logic                  instr_req_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [DATA_WIDTH-1:0] instr_rdata_i
);

  localparam int                    BYTES      = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_INC   = ADDR_WIDTH'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);
  localparam int                    PTR_W      = $clog2(DEPTH);
  localparam int                    CNT_W      = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2,
    WAIT_ABORT  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q;
  logic                  abort_q;

  logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  full, start, push, pop;
  logic                  req_d, busy_d;
  logic [ADDR_WIDTH-1:0] iaddr_d;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign start = (state_q == IDLE) & req_i & ~branch_i & ~full;
  // A redirect flushes the FIFO, so it overrides both a push and a pop.
  assign push  = (state_q == WAIT_RVALID) & instr_rvalid_i & ~branch_i;
  assign pop   = valid_o & ready_i & ~branch_i;

  assign valid_o = (count_q != '0);
  assign rdata_o = fifo_data_q[rd_ptr_q];
  assign addr_o  = fifo_addr_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = WAIT_GNT;
      end
      WAIT_GNT: begin
        if (instr_gnt_i) state_d = (abort_q | branch_i) ? WAIT_ABORT : WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (branch_i)            state_d = instr_rvalid_i ? IDLE : WAIT_ABORT;
        else if (instr_rvalid_i) state_d = IDLE;
      end
      WAIT_ABORT: begin
        if (instr_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (branch_i)          count_d = '0;
    else if (push & ~pop)  count_d = count_q + CNT_W'(1);
    else if (pop & ~push)  count_d = count_q - CNT_W'(1);

    req_d   = (state_d == WAIT_GNT);
    // The memory may sample the address after gnt, so it only moves on a new start.
    iaddr_d = start ? fetch_addr_q : instr_addr_o;
    busy_d  = (state_d != IDLE) | (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_req_o  <= 1'b0;
      instr_addr_o <= '0;
      busy_o       <= 1'b0;
    end else begin
      instr_req_o  <= req_d;
      instr_addr_o <= iaddr_d;
      busy_o       <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr_q <= BOOT_ADDR & ALIGN_MASK;
      abort_q      <= 1'b0;
    end else begin
      abort_q <= (state_q == WAIT_GNT) & ~instr_gnt_i & (abort_q | branch_i);
      if (branch_i)  fetch_addr_q <= branch_addr_i & ALIGN_MASK;
      else if (push) fetch_addr_q <= fetch_addr_q + ADDR_INC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_addr_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (branch_i) begin
        rd_ptr_q <= wr_ptr_q;
      end else begin
        if (push) begin
          fifo_data_q[wr_ptr_q] <= instr_rdata_i;
          fifo_addr_q[wr_ptr_q] <= fetch_addr_q;
          wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: a responding memory, a queue-based model of the
// delivered instruction stream checked every cycle, and directed redirect/reset cases.
module tb_instr_prefetch_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_i, branch_i, ready_i;
  logic [31:0] branch_addr_i;
  logic        valid_o, busy_o, instr_req_o;
  logic [31:0] rdata_o, addr_o, instr_addr_o;
  logic        gnt_i, rvalid_i;
  logic [31:0] rdata_mem;

  instr_prefetch_buffer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .BOOT_ADDR(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .branch_i(branch_i),
    .branch_addr_i(branch_addr_i), .ready_i(ready_i), .valid_o(valid_o),
    .rdata_o(rdata_o), .addr_o(addr_o), .busy_o(busy_o),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(gnt_i), .instr_rvalid_i(rvalid_i), .instr_rdata_i(rdata_mem)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_words [64];
  entry_t      mq[$];
  entry_t      dut_log[$];
  logic [31:0] req_log[$];
  logic [31:0] fptr, txn_addr;
  bit          txn_open, txn_granted, txn_abort;
  bit          prev_req, prev_valid;
  logic [31:0] prev_iaddr, prev_addr, prev_rdata;
  bit          mem_pending;
  int          gcnt, rcnt, gnt_delay, rvalid_delay;
  int          n_checks, n_fail;

  assign rdata_mem = mem_words[txn_addr[7:2]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: model update for the edge just taken, comparisons, then memory drive.
  task automatic cycle();
    bit rising, push_now;
    int size_before;
    @(posedge clk);
    @(negedge clk);
    rising = instr_req_o && !prev_req;
    if (!rst_n) begin
      mq.delete(); dut_log.delete(); req_log.delete();
      fptr = 32'h0; txn_open = 0; txn_granted = 0; txn_abort = 0;
      prev_req = 0; prev_valid = 0; prev_iaddr = '0; prev_addr = '0; prev_rdata = '0;
      rising = 0;
    end else begin
      size_before = mq.size();
      push_now = 0;
      if (prev_valid && ready_i && !branch_i) dut_log.push_back(entry_t'({prev_addr, prev_rdata}));
      if (prev_req && !txn_open) begin
        txn_open = 1; txn_abort = 0; txn_addr = prev_iaddr;
        req_log.push_back(prev_iaddr);
        check("req_addr", prev_iaddr, fptr);
      end
      if (branch_i && txn_open) txn_abort = 1;
      if (rvalid_i && txn_granted) begin
        push_now = !txn_abort; txn_open = 0; txn_granted = 0;
      end
      if (prev_req && gnt_i) txn_granted = 1;
      if (branch_i) begin
        mq.delete();
        fptr = branch_addr_i & 32'hFFFF_FFFC;
      end else begin
        if (mq.size() != 0 && ready_i) void'(mq.pop_front());
        if (push_now) begin
          mq.push_back(entry_t'({fptr, mem_words[fptr[7:2]]}));
          fptr = fptr + 32'd4;
        end
      end
      if (rising) begin
        check("start_not_full", size_before < DEPTH, 1);
        check("single_outstanding", txn_open, 0);
      end else begin
        check("addr_hold", instr_addr_o, prev_iaddr);
      end
      if (prev_req) check("req_until_gnt", instr_req_o, !gnt_i);
      check("valid", valid_o, mq.size() != 0);
      if (mq.size() != 0) begin
        check("head_addr", addr_o, mq[0].addr);
        check("head_data", rdata_o, mq[0].data);
      end
      check("busy", busy_o, instr_req_o || txn_granted || mq.size() != 0);
      prev_req = instr_req_o; prev_iaddr = instr_addr_o;
      prev_valid = valid_o; prev_addr = addr_o; prev_rdata = rdata_o;
    end
    if (rvalid_i) mem_pending = 0;
    if (gnt_i && rst_n) begin
      mem_pending = 1; rcnt = rvalid_delay;
    end
    gnt_i = 0; rvalid_i = 0;
    if (mem_pending) begin
      if (rcnt == 0) rvalid_i = 1;
      else rcnt--;
    end
    if (instr_req_o && rst_n) begin
      if (rising) gcnt = gnt_delay;
      if (gcnt == 0) gnt_i = 1;
      else gcnt--;
    end
  endtask

  task automatic do_reset();
    req_i = 0; branch_i = 0; ready_i = 1;
    for (int k = 0; k < 50 && (instr_req_o || mem_pending); k++) cycle();
    check("reset_quiesce", instr_req_o || mem_pending, 0);
    #1 rst_n = 0;
    cycle(); cycle();
    rst_n = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    for (int i = 0; i < 64; i++) mem_words[i] = 32'hA000_0000 | 32'(i);
    mem_words[0]  = 32'h1000_0113;
    mem_words[1]  = 32'h0010_0093;
    mem_words[18] = 32'h0262_83B3;
    req_i = 0; branch_i = 0; branch_addr_i = '0; ready_i = 0; gnt_i = 0; rvalid_i = 0;
    fptr = 0; txn_addr = 0; txn_open = 0; txn_granted = 0; txn_abort = 0;
    prev_req = 0; prev_valid = 0; prev_iaddr = 0; prev_addr = 0; prev_rdata = 0;
    mem_pending = 0; gcnt = 0; rcnt = 0; gnt_delay = 0; rvalid_delay = 0;
    n_checks = 0; n_fail = 0;

    #1 rst_n = 0;
    #1;
    check("rst_instr_req", instr_req_o, 0);
    check("rst_instr_addr", instr_addr_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_addr", addr_o, 0);
    check("rst_busy", busy_o, 0);
    cycle(); cycle();
    rst_n = 1;

    // Two words in order with a slow grant.
    gnt_delay = 2; rvalid_delay = 1; ready_i = 1; req_i = 1;
    for (int k = 0; k < 200 && dut_log.size() < 2; k++) cycle();
    check("t1_done", dut_log.size() >= 2, 1);
    check("t1_word0", dut_log[0], {32'h0, 32'h1000_0113});
    check("t1_word1", dut_log[1], {32'h4, 32'h0010_0093});

    // Decode stalled: fill to DEPTH, no further requests, then drain and resume.
    do_reset();
    gnt_delay = 0; rvalid_delay = 0; ready_i = 0; req_i = 1;
    for (int k = 0; k < 200 && mq.size() < 4; k++) cycle();
    repeat (20) cycle();
    check("t2_req_count_full", req_log.size(), 4);
    check("t2_valid_full", valid_o, 1);
    check("t2_head_full", {addr_o, rdata_o}, {32'h0, 32'h1000_0113});
    ready_i = 1;
    for (int k = 0; k < 200 && (dut_log.size() < 4 || req_log.size() < 5); k++) cycle();
    check("t2_drain0", dut_log[0], {32'h0, 32'h1000_0113});
    check("t2_drain1", dut_log[1], {32'h4, 32'h0010_0093});
    check("t2_drain2", dut_log[2], {32'h8, 32'hA000_0002});
    check("t2_drain3", dut_log[3], {32'hC, 32'hA000_0003});
    check("t2_resume_addr", req_log[4], 32'h10);

    // Redirect while waiting for the 0x8 response.
    do_reset();
    gnt_delay = 0; rvalid_delay = 3; ready_i = 1; req_i = 1;
    for (int k = 0; k < 200 && !(txn_granted && req_log.size() == 3); k++) cycle();
    check("t3_reach_rvalid", txn_granted && req_log.size() == 3, 1);
    check("t3_req_addr", req_log[2], 32'h8);
    branch_i = 1; branch_addr_i = 32'h4B;
    cycle();
    branch_i = 0;
    for (int k = 0; k < 200 && dut_log.size() < 3; k++) cycle();
    check("t3_word1", dut_log[1], {32'h4, 32'h0010_0093});
    check("t3_target", dut_log[2], {32'h48, 32'h0262_83B3});

    // Redirect during a 3-cycle grant wait.
    do_reset();
    gnt_delay = 3; rvalid_delay = 1; ready_i = 1; req_i = 1;
    for (int k = 0; k < 50 && !instr_req_o; k++) cycle();
    check("t4_req_seen", instr_req_o, 1);
    hi = 1;
    branch_i = 1; branch_addr_i = 32'h82;
    cycle();
    branch_i = 0;
    for (int k = 0; k < 20 && instr_req_o; k++) begin
      hi++;
      cycle();
    end
    check("t4_req_cycles", hi, 4);
    for (int k = 0; k < 200 && dut_log.size() < 1; k++) cycle();
    check("t4_next_req", req_log[1], 32'h80);
    check("t4_first_word", dut_log[0], {32'h80, 32'hA000_0020});

    // Redirect coinciding with a pop and an rvalid.
    do_reset();
    gnt_delay = 0; rvalid_delay = 1; ready_i = 0; req_i = 1;
    for (int k = 0; k < 200 && !(rvalid_i && valid_o); k++) cycle();
    check("t5_setup", rvalid_i && valid_o, 1);
    ready_i = 1; branch_i = 1; branch_addr_i = 32'hC0;
    cycle();
    branch_i = 0;
    check("t5_valid_after", valid_o, 0);
    check("t5_busy_after", busy_o, 0);
    check("t5_req_after", instr_req_o, 0);
    for (int k = 0; k < 200 && dut_log.size() < 1; k++) cycle();
    check("t5_req_target", req_log[2], 32'hC0);
    check("t5_first_word", dut_log[0], {32'hC0, 32'hA000_0030});

    // Reset pulse while waiting for rvalid of the 0x4 fetch.
    do_reset();
    gnt_delay = 0; rvalid_delay = 3; ready_i = 0; req_i = 1;
    for (int k = 0; k < 200 && !(txn_granted && req_log.size() == 2); k++) cycle();
    check("t6_setup", txn_granted && req_log.size() == 2, 1);
    check("t6_pre_iaddr", instr_addr_o, 32'h4);
    #2 rst_n = 0;
    #1;
    check("t6_instr_req", instr_req_o, 0);
    check("t6_instr_addr", instr_addr_o, 0);
    check("t6_valid", valid_o, 0);
    check("t6_rdata", rdata_o, 0);
    check("t6_addr", addr_o, 0);
    check("t6_busy", busy_o, 0);
    req_i = 0; ready_i = 1;
    cycle(); cycle();
    rst_n = 1;
    repeat (6) cycle();
    check("t6_late_ignored", valid_o, 0);
    req_i = 1;
    for (int k = 0; k < 200 && dut_log.size() < 1; k++) cycle();
    check("t6_restart_req", req_log[0], 32'h0);
    check("t6_restart_word", dut_log[0], {32'h0, 32'h1000_0113});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
